// File: rtl/adc_trigger_capture_pkg.sv
// Shared definitions for the ADC trigger/capture engine: FSM state codes and slope selects.
package adc_trigger_capture_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PREFILL   = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_POST      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/adc_trigger_capture_if.sv
// ADC sample/control inputs and capture-RAM write/status outputs of adc_trigger_capture.
interface adc_trigger_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [ADDR_W-1:0] pretrig;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              done;
  logic              auto_fired;

  modport master (
    output adc_data, adc_valid, arm, force_trig, trig_level, trig_slope, pretrig,
    input  wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, auto_fired
  );

  modport slave (
    input  adc_data, adc_valid, arm, force_trig, trig_level, trig_slope, pretrig,
    output wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, auto_fired
  );
endinterface

// File: rtl/adc_trigger_capture_trig_detect.sv
// Level/slope trigger detector: tracks the previous valid sample and flags a crossing combinationally.
module trig_detect
  import adc_trigger_capture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              trig_hit
);
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              crossed;

  // prev follows every valid sample, so history from PREFILL is available in WAIT_TRIG
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    if (slope == SLOPE_RISING) crossed = (prev < level) && (sample >= level);
    else                       crossed = (prev > level) && (sample <= level);
    trig_hit = enable && valid && prev_valid && crossed;
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Triggered ADC acquisition: circular pre-trigger history, level/slope/forced trigger, capture-RAM writes.
// Define CAPTURE_AUTO_TRIG_EN to enable the WAIT_TRIG auto-trigger timeout (AUTO_TIMEOUT cycles).
module adc_trigger_capture
  import adc_trigger_capture_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 12,
  parameter int AUTO_TIMEOUT = 1024
) (
  input logic                  clk,
  input logic                  rst,
  adc_trigger_capture_if.slave bus
);
  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] pretrig_eff;
  logic              force_pend;
  logic              auto_pend;
  logic              trig_hit;
  logic              in_wait;
  logic              writing;
  logic              arm_ok;
  logic              fire;

  always_comb begin
    in_wait = (state == ST_WAIT_TRIG);
    writing = bus.adc_valid && is_busy(state);
    arm_ok  = bus.arm && ((state == ST_IDLE) || (state == ST_DONE));
    fire    = trig_hit ||
              (in_wait && bus.adc_valid && (force_pend || bus.force_trig || auto_pend));
  end

  trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk      (clk),
    .rst      (rst),
    .clear    (arm_ok),
    .enable   (in_wait),
    .valid    (bus.adc_valid),
    .sample   (bus.adc_data),
    .level    (bus.trig_level),
    .slope    (bus.trig_slope),
    .trig_hit (trig_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      cnt            <= '0;
      pretrig_eff    <= '0;
      force_pend     <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.trig_addr  <= '0;
      bus.start_addr <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.wr_en <= writing;
      bus.busy  <= is_busy(state);
      bus.done  <= (state == ST_DONE);
      if (writing) begin
        bus.wr_addr <= wr_ptr;
        bus.wr_data <= bus.adc_data;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm_ok) begin
            // an ADDR_W-wide PRETRIG never exceeds DEPTH-1, so the clamp is the value itself
            wr_ptr      <= '0;
            force_pend  <= 1'b0;
            pretrig_eff <= bus.pretrig;
            cnt         <= bus.pretrig;
            state       <= (bus.pretrig == '0) ? ST_WAIT_TRIG : ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (bus.adc_valid) begin
            cnt <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (fire) begin
            bus.trig_addr  <= wr_ptr;
            bus.start_addr <= wr_ptr - pretrig_eff;
            force_pend     <= 1'b0;
            // DEPTH-1-pretrig_eff is the ADDR_W-bit complement
            cnt            <= ~pretrig_eff;
            state          <= (pretrig_eff == '1) ? ST_DONE : ST_POST;
          end else if (bus.force_trig) begin
            force_pend <= 1'b1;
          end
        end
        ST_POST: begin
          if (bus.adc_valid) begin
            cnt <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
  logic [CNT_W-1:0] auto_cnt;

  // counter idles at zero outside WAIT_TRIG, so each entry starts a fresh timeout
  always_ff @(posedge clk) begin
    if (rst || !in_wait) begin
      auto_cnt  <= '0;
      auto_pend <= 1'b0;
    end else if (!auto_pend) begin
      auto_cnt <= auto_cnt + CNT_W'(1);
      if (auto_cnt == CNT_W'(AUTO_TIMEOUT - 1)) auto_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arm_ok)          bus.auto_fired <= 1'b0;
    else if (fire && auto_pend) bus.auto_fired <= 1'b1;
  end
`else
  localparam int unused_auto_timeout = AUTO_TIMEOUT;
  assign auto_pend      = 1'b0;
  assign bus.auto_fired = 1'b0;
`endif

endmodule
